// File: rtl/alu_74181_pkg.sv
// Shared types and constants for the nibble-serial 74181 sequencer.
// Carry helper mirrors the 74182 lookahead equation for one group.
package alu_74181_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;
  localparam logic [3:0] S_AND = 4'b1011;
  localparam logic [3:0] S_OR  = 4'b1110;
  localparam logic [3:0] S_XOR = 4'b0110;

  function automatic logic cla_carry(
    input logic g_n,
    input logic p_n,
    input logic cin
  );
    return ~g_n | (~p_n & cin);
  endfunction

endpackage

// File: rtl/alu_74181.sv
// Behavioural 4-bit 74181 slice: active-high data, active-low Cn/G/P.
// A=B is the AND of the F outputs, as on the open-collector pin.
module alu_74181 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] s_i,
  input  logic       m_i,
  input  logic       cn_n_i,
  output logic [3:0] f_o,
  output logic       eq_o,
  output logic       g_n_o,
  output logic       p_n_o
);

  logic [3:0] w_p;
  logic [3:0] w_g;

  // per-bit propagate/generate terms selected by S
  always_comb begin
    w_p = '0;
    w_g = '0;
    for (int i = 0; i < 4; i++) begin
      w_p[i] = a_i[i] | (b_i[i] & s_i[0]) | (~b_i[i] & s_i[1]);
      w_g[i] = (a_i[i] & ~b_i[i] & s_i[2]) | (a_i[i] & b_i[i] & s_i[3]);
    end
  end

  // ripple internal carries, form F and group G/P
  always_comb begin
    logic c;
    logic gg;
    c  = ~cn_n_i;
    gg = 1'b0;
    f_o = '0;
    for (int i = 0; i < 4; i++) begin
      f_o[i] = m_i ? ~(w_p[i] ^ w_g[i]) : (w_p[i] ^ w_g[i] ^ c);
      c  = w_g[i] | (w_p[i] & c);
      gg = w_g[i] | (w_p[i] & gg);
    end
    g_n_o = ~gg;
    p_n_o = ~(&w_p);
    eq_o  = &f_o;
  end

endmodule

// File: rtl/alu_74181_seq.sv
// Runs one shared 74181 over a WIDTH-bit operand, one nibble per cycle.
// Carry ripples between passes from the ALU's group G/P outputs.
import alu_74181_pkg::*;

module alu_74181_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       req_s_i,
  input  logic             req_m_i,
  input  logic             req_carry_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_f_o,
  output logic             rsp_carry_o,
  output logic             rsp_equal_o,
  output logic [3:0]       alu_s_o,
  output logic             alu_m_o,
  output logic             alu_cn_o,
  output logic [3:0]       alu_a_o,
  output logic [3:0]       alu_b_o,
  input  logic [3:0]       alu_f_i,
  input  logic             alu_eq_i,
  input  logic             alu_g_n_i,
  input  logic             alu_p_n_i
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("alu_74181_seq: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t           r_state;
  state_t           w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_s;
  logic             r_m;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_f;
  logic             r_carry;
  logic             r_eq;
  logic             w_run;
  logic             w_accept;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;

  assign w_run       = (r_state == RUN);
  assign req_ready_o = (r_state == IDLE) & ~rst_i;
  assign w_accept    = req_valid_i & req_ready_o & ~flush_i;

  assign rsp_valid_o = (r_state == DONE);
  assign rsp_f_o     = r_f;
  assign rsp_carry_o = r_carry;
  assign rsp_equal_o = r_eq;

  assign alu_s_o  = w_run ? r_s : 4'd0;
  assign alu_m_o  = w_run & r_m;
  assign alu_cn_o = ~(w_run & r_carry);
  assign alu_a_o  = w_run ? w_a_nib : 4'd0;
  assign alu_b_o  = w_run ? w_b_nib : 4'd0;

  // select the operand nibble addressed by the pass counter
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_nib = r_a[i*4 +: 4];
        w_b_nib = r_b[i*4 +: 4];
      end
    end
  end

  // next state; flush overrides every handshake
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_state_nx = RUN;
      RUN:  if (r_cnt == LAST) w_state_nx = DONE;
      DONE: if (rsp_ready_i) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (flush_i) w_state_nx = IDLE;
  end

  // state, operand latch and per-pass result capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_s     <= '0;
      r_m     <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_f     <= '0;
      r_carry <= 1'b0;
      r_eq    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (!flush_i) begin
        unique case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_s     <= req_s_i;
              r_m     <= req_m_i;
              r_a     <= req_a_i;
              r_b     <= req_b_i;
              r_carry <= req_carry_i;
              r_cnt   <= '0;
              r_eq    <= 1'b1;
            end
          end
          RUN: begin
            for (int i = 0; i < NIBBLES; i++) begin
              if (r_cnt == CW'(i)) r_f[i*4 +: 4] <= alu_f_i;
            end
            r_eq    <= r_eq & alu_eq_i;
            r_carry <= r_m ? 1'b0
                     : cla_carry(alu_g_n_i, alu_p_n_i, r_carry);
            if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_74181_seq.sv
// Randomised and directed bench for the nibble-serial 74181 sequencer.
// Whole-word datasheet function table is the reference.
module tb_alu_74181_seq;
  import alu_74181_pkg::*;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_s = '0;
  logic         req_m = 1'b0;
  logic         req_c = 1'b0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_f;
  logic         rsp_carry;
  logic         rsp_equal;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_cn;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [3:0]   alu_f;
  logic         alu_eq;
  logic         alu_g_n;
  logic         alu_p_n;

  int           n_chk = 0;
  int           n_fail = 0;
  logic         cn_q[$];
  logic [W-1:0] g_f;
  logic         g_c;
  logic         g_eq;

  always #5 clk = ~clk;

  alu_74181_seq #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_s_i(req_s), .req_m_i(req_m), .req_carry_i(req_c),
    .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_f_o(rsp_f), .rsp_carry_o(rsp_carry), .rsp_equal_o(rsp_equal),
    .alu_s_o(alu_s), .alu_m_o(alu_m), .alu_cn_o(alu_cn),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_f_i(alu_f),
    .alu_eq_i(alu_eq), .alu_g_n_i(alu_g_n), .alu_p_n_i(alu_p_n)
  );

  alu_74181 u_alu (
    .a_i(alu_a), .b_i(alu_b), .s_i(alu_s), .m_i(alu_m),
    .cn_n_i(alu_cn), .f_o(alu_f), .eq_o(alu_eq),
    .g_n_o(alu_g_n), .p_n_o(alu_p_n)
  );

  // returns {equal, carry, f} for a whole-word operation
  function automatic logic [W+1:0] ref_op(
    input logic [3:0] s, input logic m, input logic c,
    input logic [W-1:0] a, input logic [W-1:0] b
  );
    logic [W-1:0] x, y, f;
    logic [W:0]   sum;
    logic         co;
    x = '0; y = '0; f = '0; co = 1'b0; sum = '0;
    if (m) begin
      case (s)
        4'd0:  f = ~a;
        4'd1:  f = ~(a | b);
        4'd2:  f = ~a & b;
        4'd3:  f = '0;
        4'd4:  f = ~(a & b);
        4'd5:  f = ~b;
        4'd6:  f = a ^ b;
        4'd7:  f = a & ~b;
        4'd8:  f = ~a | b;
        4'd9:  f = ~(a ^ b);
        4'd10: f = b;
        4'd11: f = a & b;
        4'd12: f = '1;
        4'd13: f = a | ~b;
        4'd14: f = a | b;
        default: f = a;
      endcase
    end else begin
      case (s)
        4'd0:  begin x = a;      y = '0;     end
        4'd1:  begin x = a | b;  y = '0;     end
        4'd2:  begin x = a | ~b; y = '0;     end
        4'd3:  begin x = '1;     y = '0;     end
        4'd4:  begin x = a;      y = a & ~b; end
        4'd5:  begin x = a | b;  y = a & ~b; end
        4'd6:  begin x = a;      y = ~b;     end
        4'd7:  begin x = '1;     y = a & ~b; end
        4'd8:  begin x = a;      y = a & b;  end
        4'd9:  begin x = a;      y = b;      end
        4'd10: begin x = a | ~b; y = a & b;  end
        4'd11: begin x = '1;     y = a & b;  end
        4'd12: begin x = a;      y = a;      end
        4'd13: begin x = a | b;  y = a;      end
        4'd14: begin x = a | ~b; y = a;      end
        default: begin x = '1;   y = a;      end
      endcase
      sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      f   = sum[W-1:0];
      co  = sum[W];
    end
    return {&f, co, f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // present a request at a negedge; returns one negedge after the accept
  task automatic send(input logic [3:0] s, input logic m, input logic c,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    req_s = s; req_m = m; req_c = c; req_a = a; req_b = b;
    req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_s = 4'($urandom); req_m = 1'($urandom); req_c = 1'($urandom);
    req_a = W'($urandom); req_b = W'($urandom);
  endtask

  // count negedges from accept until rsp_valid, logging alu_cn per pass
  task automatic wait_rsp(output int lat);
    cn_q.delete();
    lat = 1;
    if (!rsp_valid) cn_q.push_back(alu_cn);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!rsp_valid) cn_q.push_back(alu_cn);
    end
    chk("latency", lat, NIB + 1);
    g_f = rsp_f; g_c = rsp_carry; g_eq = rsp_equal;
  endtask

  task automatic release_rsp(input int hold);
    for (int i = 0; i < hold; i++) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("back_idle", req_ready, 1);
  endtask

  task automatic run_op(input logic [3:0] s, input logic m, input logic c,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+1:0] e;
    int lat;
    e = ref_op(s, m, c, a, b);
    send(s, m, c, a, b);
    wait_rsp(lat);
    chk("f", g_f, e[W-1:0]);
    chk("carry", g_c, e[W]);
    chk("equal", g_eq, e[W+1]);
    release_rsp(int'($urandom_range(0, 2)));
  endtask

  initial begin
    logic [W+1:0] e;
    logic [W-1:0] hold_f;
    int lat;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_f", rsp_f, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    chk("rst_rsp_equal", rsp_equal, 0);
    chk("rst_alu_cn", alu_cn, 1);
    chk("rst_alu_bus", {alu_s, alu_m, alu_a, alu_b}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    // flush beats a simultaneous request in IDLE
    req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_req", req_ready, 1);

    run_op(S_ADD, 1'b0, 1'b0, 16'h00FF, 16'h0001);
    chk("add_f", g_f, 16'h0100);
    chk("add_c", g_c, 0);

    run_op(S_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
    chk("ovf_f", g_f, 16'h0000);
    chk("ovf_c", g_c, 1);
    chk("cn_count", cn_q.size(), NIB);
    if (cn_q.size() == NIB)
      chk("cn_seq", {cn_q[0], cn_q[1], cn_q[2], cn_q[3]}, 4'b1000);

    run_op(S_SUB, 1'b0, 1'b0, 16'h1234, 16'h1234);
    chk("eq_f", g_f, 16'hFFFF);
    chk("eq_hit", g_eq, 1);
    run_op(S_SUB, 1'b0, 1'b0, 16'h1234, 16'h1235);
    chk("eq_miss", g_eq, 0);

    run_op(S_AND, 1'b1, 1'b1, 16'hF0F0, 16'hFF00);
    chk("and_f", g_f, 16'hF000);
    chk("and_c", g_c, 0);

    // backpressure with a competing request held during DONE
    e = ref_op(S_XOR, 1'b1, 1'b0, 16'hA5A5, 16'h0FF0);
    send(S_XOR, 1'b1, 1'b0, 16'hA5A5, 16'h0FF0);
    wait_rsp(lat);
    hold_f = rsp_f;
    chk("bp_f", hold_f, e[W-1:0]);
    req_s = S_OR; req_m = 1'b1; req_c = 1'b0;
    req_a = 16'h1200; req_b = 16'h0034;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_f_hold", rsp_f, hold_f);
      chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_idle", req_ready, 1);
    chk("bp_drop", rsp_valid, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_accept", req_ready, 0);
    wait_rsp(lat);
    chk("bp_new_f", g_f, 16'h1234);
    release_rsp(0);

    // flush during the second pass
    send(S_ADD, 1'b0, 1'b1, 16'h7777, 16'h1111);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", req_ready, 1);
    chk("flush_cn", alu_cn, 1);
    chk("flush_bus", {alu_s, alu_a, alu_b}, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_no_rsp", rsp_valid, 0);
    end
    run_op(S_ADD, 1'b0, 1'b1, 16'h7777, 16'h1111);

    // reset while the response is pending
    send(S_ADD, 1'b0, 1'b0, 16'h4321, 16'h1111);
    wait_rsp(lat);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_done_ready", req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done_idle", req_ready, 1);
    chk("rst_done_valid", rsp_valid, 0);
    chk("rst_done_cn", alu_cn, 1);
    chk("rst_done_f", rsp_f, 0);
    run_op(S_ADD, 1'b0, 1'b0, 16'h4321, 16'h1111);
    chk("after_rst_f", g_f, 16'h5432);

    for (int k = 0; k < 60; k++) begin
      run_op(4'($urandom), 1'($urandom), 1'($urandom),
             W'($urandom), W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_74181_seq.md
Name: alu_74181_seq

Overview:
Multi-cycle sequencer that runs one 4-bit alu_74181 over a WIDTH-bit operation, one nibble per cycle from LSB to MSB. It ripples carry between nibbles from the ALU's G/P outputs. It uses a valid/ready request/response handshake toward the core. It sits between the core datapath and a single shared alu_74181 instance and owns all of that instance's inputs.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8 (elaboration error otherwise)
NIBBLES, WIDTH/4, derived local constant; number of ALU passes

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
flush_i  in  1  synchronous abort; returns FSM to IDLE
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_s_i  in  4  74181 function select S3..S0
req_m_i  in  1  mode: 1=logic, 0=arithmetic
req_carry_i  in  1  active-high carry-in for nibble 0
req_a_i  in  WIDTH  operand A, active-high data
req_b_i  in  WIDTH  operand B, active-high data
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  result consumed when valid&ready
rsp_f_o  out  WIDTH  result
rsp_carry_o  out  1  active-high carry out of MSB nibble; 0 in logic mode
rsp_equal_o  out  1  AND of ALU A=B output over all nibbles
alu_s_o  out  4  to ALU S
alu_m_o  out  1  to ALU M
alu_cn_o  out  1  to ALU carry-in, 74181 active-low convention (0 = carry)
alu_a_o  out  4  to ALU A
alu_b_o  out  4  to ALU B
alu_f_i  in  4  from ALU F
alu_eq_i  in  1  from ALU A=B
alu_g_n_i  in  1  from ALU G, active-low generate
alu_p_n_i  in  1  from ALU P, active-low propagate

Behaviour:
- Clocking and reset: single clock clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: state=IDLE; nibble counter=0; operand, result and carry registers=0; rsp_valid_o=0; rsp_f_o=0; rsp_carry_o=0; rsp_equal_o=0; all alu_*_o=0 except alu_cn_o=1.
- req_ready_o=0 while rst_i is high. After reset, req_ready_o = (state==IDLE).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On req_valid_i & req_ready_o: latch S, M, A, B into registers; set carry_q=req_carry_i, cnt=0, eq_acc=1; go to RUN.
  - No other state change.
- RUN, each cycle:
  - Drive alu_a_o/alu_b_o from nibble cnt of the latched A/B. alu_s_o/alu_m_o come from the latched S/M. alu_cn_o = ~carry_q.
  - The ALU is combinational; capture alu_f_i into rsp_f nibble cnt on the same clock edge.
  - eq_acc <= eq_acc & alu_eq_i.
  - carry_q <= M ? 0 : (~alu_g_n_i | (~alu_p_n_i & carry_q)).
  - When cnt==NIBBLES-1, go to DONE. Otherwise cnt <= cnt+1.
- DONE:
  - rsp_valid_o=1. rsp_f_o, rsp_carry_o=carry_q and rsp_equal_o=eq_acc are held stable.
  - On rsp_ready_i, go to IDLE.
  - No new request is accepted in DONE (no back-to-back overlap).
- Latency: rsp_valid_o asserts exactly NIBBLES+1 cycles after the accepting edge (5 cycles for WIDTH=16).
- Throughput: at most one operation per NIBBLES+2 cycles.
- Outside RUN: alu_*_o are held at their reset values.
- Response outputs: registered, not combinational from alu_*_i. rsp_valid_o is 0 outside DONE. rsp_f_o is undefined outside DONE, but implementation keeps the last value.
- flush_i: in any state, go to IDLE next cycle and drop rsp_valid_o. Partial results are discarded. flush_i has priority over handshakes in the same cycle.
- rst_i mid-RUN or in DONE: behaves as reset; the response is lost and no rsp_valid_o pulse is produced.
- Simultaneous req_valid_i and flush_i in IDLE: the request is not accepted.
- Mode/operand changes on req_* while not IDLE are ignored.

Decomposition:
- Package alu_74181_pkg:
  - state enum (IDLE, RUN, DONE)
  - S-code localparams: ADD=4'b1001, SUB=4'b0110, AND=4'b1011, OR=4'b1110, XOR=4'b0110 with M=1
  - carry-lookahead helper function (g_n, p_n, cin) -> cout
- No sub-module. The alu_74181 instance lives in the parent, wired through the alu_* ports. The bench instantiates the real alu_74181 behind the sequencer.

Test Plan:
- Add, WIDTH=16: S=1001, M=0, carry=0, A=0x00FF, B=0x0001 -> rsp_f_o=0x0100, rsp_carry_o=0, rsp_valid_o 5 cycles after accept.
- Add overflow: A=0xFFFF, B=0x0001, carry=0 -> rsp_f_o=0x0000, rsp_carry_o=1; alu_cn_o observed 1,0,0,0 across the four RUN cycles.
- Equality: S=0110, M=0, carry=0, A=B=0x1234 -> rsp_f_o=0xFFFF, rsp_equal_o=1. Repeat with B=0x1235 -> rsp_equal_o=0.
- Logic AND: S=1011, M=1, carry=1, A=0xF0F0, B=0xFF00 -> rsp_f_o=0xF000, rsp_carry_o=0.
- Backpressure: hold rsp_ready_i=0 for 10 cycles -> rsp_valid_o and outputs stable, req_ready_o=0. Raise rsp_ready_i -> IDLE next cycle; a new request is accepted the cycle after.
- flush_i in 2nd RUN cycle, and separately rst_i in DONE -> IDLE next cycle, rsp_valid_o never/no longer asserted, alu_cn_o=1. A subsequent request completes correctly.
